// File: rtl/div_unit_if.sv
// Opcode constants shared with the ALU decoder, and the pipeline <-> divider port bundle.
// The pipeline side drives the request; the divider answers with stall, strobe and result.
package div_defs_pkg;
    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;
endpackage

interface div_unit_if;
    logic [7:0]  alucontrol;
    logic [31:0] a;
    logic [31:0] b;
    logic        annul;
    logic        div_stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output alucontrol, a, b, annul,
                     input  div_stall, done, hi, lo);
    modport slave  (input  alucontrol, a, b, annul,
                     output div_stall, done, hi, lo);
endinterface

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for the MIPS DIV/DIVU instructions.
// Quotient goes to lo, remainder to hi; divide by zero yields zeros without a trap.
module div_unit
    import div_defs_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    div_unit_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_t;

    state_t      state;
    logic [5:0]  cnt;
    logic [31:0] dvd_q;      // dividend magnitude, quotient bits shift in from the right
    logic [31:0] dvs;
    logic [31:0] rem;
    logic        neg_q;
    logic        neg_r;
    logic        done_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic        is_div;
    logic        is_signed;
    logic        start;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic        fits;
    logic [31:0] rem_next;
    logic [31:0] quo_next;

    assign is_div    = (bus.alucontrol == EXE_DIV_OP) || (bus.alucontrol == EXE_DIVU_OP);
    assign is_signed = (bus.alucontrol == EXE_DIV_OP);
    assign start     = (state == IDLE) && is_div && !bus.annul;
    assign a_neg     = is_signed && bus.a[31];
    assign b_neg     = is_signed && bus.b[31];
    assign mag_a     = a_neg ? (~bus.a + 32'd1) : bus.a;
    assign mag_b     = b_neg ? (~bus.b + 32'd1) : bus.b;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        shifted  = {rem, dvd_q[31]};
        diff     = shifted - {1'b0, dvs};
        fits     = (shifted >= {1'b0, dvs});
        rem_next = shifted[31:0];
        if (fits) begin
            rem_next = diff[31:0];
        end
        quo_next = {dvd_q[30:0], fits};
    end

    // Stall is raised in the start cycle itself so the pipeline freezes before ON begins.
    assign bus.div_stall = rst && (start || (state == BYZERO) || (state == ON));
    assign bus.done      = done_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= 6'd0;
            dvd_q  <= 32'd0;
            dvs    <= 32'd0;
            rem    <= 32'd0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            done_q <= 1'b0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        dvd_q <= mag_a;
                        dvs   <= mag_b;
                        rem   <= 32'd0;
                        cnt   <= 6'd0;
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        state <= (bus.b == 32'd0) ? BYZERO : ON;
                    end
                end
                BYZERO: begin
                    if (bus.annul) begin
                        state <= IDLE;
                    end else begin
                        state  <= END;
                        done_q <= 1'b1;
                        hi_q   <= 32'd0;
                        lo_q   <= 32'd0;
                    end
                end
                ON: begin
                    if (bus.annul) begin
                        state <= IDLE;
                        cnt   <= 6'd0;
                    end else begin
                        dvd_q <= quo_next;
                        rem   <= rem_next;
                        cnt   <= cnt + 6'd1;
                        if (cnt == 6'd31) begin
                            // Sign fix-up on the last iteration; MIN/-1 wraps back to MIN.
                            state  <= END;
                            cnt    <= 6'd0;
                            done_q <= 1'b1;
                            lo_q   <= neg_q ? (~quo_next + 32'd1) : quo_next;
                            hi_q   <= neg_r ? (~rem_next + 32'd1) : rem_next;
                        end
                    end
                end
                END: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: scoreboard of expected {hi,lo} pushed at start, popped at done,
// plus latency, stall, annul and reset behaviour.
module tb_div_unit;
    import div_defs_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_unit_if bus ();

    div_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp    = 0;
    int n_bad    = 0;
    int done_cnt = 0;
    logic [63:0] sb_q[$];   // {hi, lo}

    always @(negedge clk) begin
        if (bus.done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model built on the language's own division operators.
    function automatic logic [63:0] model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [31:0] q;
        logic signed [31:0] r;
        sa = a;
        sb = b;
        if (b == 32'd0) return 64'd0;
        if (op == EXE_DIVU_OP) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {r, q};
    endfunction

    task automatic start_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp_hi, input logic [31:0] exp_lo, input bit expect_done);
        @(negedge clk);
        bus.alucontrol = op;
        bus.a          = a;
        bus.b          = b;
        bus.annul      = 1'b0;
        if (expect_done) sb_q.push_back({exp_hi, exp_lo});
        #1;
        check("stall_at_start", {31'd0, bus.div_stall}, 32'd1);
    endtask

    task automatic wait_done(input int exp_lat, input bit annul_end);
        int got    = 0;
        int stalls = 1;
        logic [63:0] e;
        for (int k = 1; k <= exp_lat + 8 && got == 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.alucontrol = 8'h00;
                bus.a          = $urandom;
                bus.b          = $urandom;
            end
            if (annul_end && k == exp_lat) bus.annul = 1'b1;
            #1;
            if (bus.div_stall === 1'b1) stalls++;
            if (bus.done === 1'b1) got = k;
        end
        bus.annul = 1'b0;
        check("latency", got, exp_lat);
        check("stall_cycles", stalls, exp_lat);
        if (got != 0) begin
            check("sb_depth", sb_q.size(), 1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("lo", bus.lo, e[31:0]);
                check("hi", bus.hi, e[63:32]);
            end
        end
    endtask

    initial begin
        logic [31:0] a_r;
        logic [31:0] b_r;
        logic [7:0]  op_r;
        logic [63:0] m;
        int          dc;

        rst            = 1'b0;
        bus.alucontrol = EXE_DIVU_OP;
        bus.a          = 32'd100;
        bus.b          = 32'd7;
        bus.annul      = 1'b0;
        #1;
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_stall", {31'd0, bus.div_stall}, 32'd0);
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        bus.alucontrol = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Non-divide opcode keeps the block idle
        @(negedge clk);
        bus.alucontrol = 8'h21;
        #1;
        check("other_op_stall", {31'd0, bus.div_stall}, 32'd0);
        repeat (3) @(negedge clk);
        #1;
        check("other_op_done", done_cnt, 0);
        check("other_op_stall2", {31'd0, bus.div_stall}, 32'd0);

        // annul in IDLE blocks a start
        @(negedge clk);
        bus.alucontrol = EXE_DIVU_OP;
        bus.annul      = 1'b1;
        #1;
        check("annul_idle_stall", {31'd0, bus.div_stall}, 32'd0);
        @(negedge clk);
        bus.alucontrol = 8'h00;
        bus.annul      = 1'b0;
        #1;
        check("annul_idle_no_start", {31'd0, bus.div_stall}, 32'd0);

        // DIVU 100/7, then results hold
        start_div(EXE_DIVU_OP, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);
        wait_done(33, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        check("hold_lo", bus.lo, 32'd14);
        check("hold_hi", bus.hi, 32'd2);
        check("hold_done", {31'd0, bus.done}, 32'd0);

        // Divide by zero
        start_div(EXE_DIVU_OP, 32'd55, 32'd0, 32'd0, 32'd0, 1'b1);
        wait_done(2, 1'b0);

        // Signed cases; annul during END must not suppress done
        start_div(EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);
        wait_done(33, 1'b0);
        start_div(EXE_DIV_OP, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b1);
        wait_done(33, 1'b1);

        // Annul mid-divide: back to IDLE, no done, hi/lo untouched
        dc = done_cnt;
        start_div(EXE_DIVU_OP, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k == 1) bus.alucontrol = 8'h00;
            bus.annul = (k == 10);
        end
        #1;
        check("annul_to_idle", {31'd0, bus.div_stall}, 32'd0);
        repeat (30) @(negedge clk);
        #1;
        check("annul_no_done", done_cnt, dc);
        check("annul_keep_lo", bus.lo, 32'hFFFF_FFFD);
        check("annul_keep_hi", bus.hi, 32'h0000_0001);
        start_div(EXE_DIVU_OP, 32'd9, 32'd2, 32'd1, 32'd4, 1'b1);
        wait_done(33, 1'b0);

        // Signed overflow case
        start_div(EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b1);
        wait_done(33, 1'b0);

        // Reset mid-divide, asserted between clock edges
        dc = done_cnt;
        start_div(EXE_DIVU_OP, 32'd1000, 32'd3, 32'd0, 32'd0, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) bus.alucontrol = 8'h00;
        end
        #2 rst = 1'b0;
        #1;
        check("arst_done", {31'd0, bus.done}, 32'd0);
        check("arst_stall", {31'd0, bus.div_stall}, 32'd0);
        check("arst_hi", bus.hi, 32'd0);
        check("arst_lo", bus.lo, 32'd0);
        #3 rst = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        check("arst_no_done", done_cnt, dc);
        check("arst_idle", {31'd0, bus.div_stall}, 32'd0);

        // Back-to-back: second divide presented the cycle after END
        start_div(EXE_DIVU_OP, 32'd50, 32'd5, 32'd0, 32'd10, 1'b1);
        wait_done(33, 1'b0);
        start_div(EXE_DIV_OP, 32'hFFFF_FFF6, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);
        wait_done(33, 1'b0);

        // A few random operands against the reference model
        for (int i = 0; i < 6; i++) begin
            op_r = ($urandom_range(0, 1) == 0) ? EXE_DIV_OP : EXE_DIVU_OP;
            a_r  = $urandom;
            b_r  = (i == 2) ? 32'd1 : ($urandom >> $urandom_range(0, 28));
            m    = model(op_r, a_r, b_r);
            start_div(op_r, a_r, b_r, m[63:32], m[31:0], 1'b1);
            wait_done((b_r == 32'd0) ? 2 : 33, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
